// File: rtl/w5300_bus_responder_if.sv
// W5300 host bus strobes and address, shared by the host-side driver (master)
// and the chip-side responder (slave). The 16-bit data bus is a tristate pin
// and stays a plain inout port on each module.
`timescale 1ns/1ps

interface w5300_bus_responder_if;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [9:0] addr;

    modport master (
        output cs_n,
        output rd_n,
        output wr_n,
        output addr
    );

    modport slave (
        input cs_n,
        input rd_n,
        input wr_n,
        input addr
    );
endinterface

// File: rtl/w5300_bus_responder.sv
// Chip-side responder for the W5300 16-bit direct-address host bus.
// Samples the host strobes through two-flop synchronisers, serves reads from a
// small register file with W5300 reset values and commits writes on strobe
// release. Optional protocol error counter: define W5300_RSP_ERR_CNT_EN.
`timescale 1ns/1ps

module w5300_bus_responder #(
    parameter int unsigned REG_WORDS  = 32,
    parameter int unsigned BOOT_TICKS = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_rst_n,
    w5300_bus_responder_if.slave        bus,
    inout  wire  [15:0]                 data,
    output logic                        busy,
    output logic                        wr_evt,
    output logic [9:0]                  wr_evt_addr,
    output logic [15:0]                 wr_evt_data
`ifdef W5300_RSP_ERR_CNT_EN
    ,
    output logic [7:0]                  err_cnt
`endif
);

    localparam int unsigned IdxW = (REG_WORDS > 1) ? $clog2(REG_WORDS) : 1;
    localparam int unsigned CntW = (BOOT_TICKS > 1) ? $clog2(BOOT_TICKS) : 1;

    localparam logic [15:0] MrReset = 16'hB800;
    localparam logic [15:0] IdrWord = 16'h5300;
    localparam logic [8:0]  IdrIdx  = 9'h1FF;

    typedef enum logic [2:0] {
        StReset,
        StBoot,
        StIdle,
        StRead,
        StWrite,
        StError
    } state_e;

    state_e state_q, state_d;

    // Synchronised copies of the host pins
    logic        w_rst_n_s1, w_rst_n_s;
    logic        cs_n_s1, cs_n_s;
    logic        rd_n_s1, rd_n_s;
    logic        wr_n_s1, wr_n_s;
    logic [9:0]  addr_s1, addr_s;
    logic [15:0] data_s1, data_s;

    logic [CntW-1:0] cnt_q;
    logic            boot_done;

    logic [15:0] regs_q [REG_WORDS];
    logic [15:0] rd_word_q;
    logic [15:0] wr_hold_q;
    logic [15:0] map_word;

    logic [8:0]      word_idx;
    logic [IdxW-1:0] reg_idx;
    logic            is_idr;
    logic            in_range;
    logic            reg_we;

    logic collide;
    logic commit;
    logic err_entry;
    logic rd_oe;

    logic        wr_evt_q;
    logic [9:0]  wr_evt_addr_q;
    logic [15:0] wr_evt_data_q;

    // Two-flop synchronisers; strobes idle high, chip reset held until sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rst_n_s1 <= 1'b0;
            w_rst_n_s  <= 1'b0;
            cs_n_s1    <= 1'b1;
            cs_n_s     <= 1'b1;
            rd_n_s1    <= 1'b1;
            rd_n_s     <= 1'b1;
            wr_n_s1    <= 1'b1;
            wr_n_s     <= 1'b1;
            addr_s1    <= '0;
            addr_s     <= '0;
            data_s1    <= '0;
            data_s     <= '0;
        end else begin
            w_rst_n_s1 <= w_rst_n;
            w_rst_n_s  <= w_rst_n_s1;
            cs_n_s1    <= bus.cs_n;
            cs_n_s     <= cs_n_s1;
            rd_n_s1    <= bus.rd_n;
            rd_n_s     <= rd_n_s1;
            wr_n_s1    <= bus.wr_n;
            wr_n_s     <= wr_n_s1;
            addr_s1    <= bus.addr;
            addr_s     <= addr_s1;
            data_s1    <= data;
            data_s     <= data_s1;
        end
    end

    // Address decode on the synchronised word index
    always_comb begin
        word_idx = addr_s[9:1];
        reg_idx  = word_idx[IdxW-1:0];
        is_idr   = (word_idx == IdrIdx);
        in_range = (32'(word_idx) < REG_WORDS);
        map_word = 16'h0000;
        if (is_idr) begin
            map_word = IdrWord;
        end else if (in_range) begin
            map_word = regs_q[reg_idx];
        end
    end

    assign boot_done = (cnt_q == CntW'(BOOT_TICKS - 1));
    assign collide   = !cs_n_s && !rd_n_s && !wr_n_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, commit and error-entry decode
    always_comb begin
        state_d   = state_q;
        commit    = 1'b0;
        err_entry = 1'b0;
        if (!w_rst_n_s) begin
            state_d = StReset;
        end else begin
            case (state_q)
                StReset: begin
                    state_d = StBoot;
                end
                StBoot: begin
                    if (boot_done) begin
                        state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (collide) begin
                        state_d   = StError;
                        err_entry = 1'b1;
                    end else if (!cs_n_s && !rd_n_s && wr_n_s) begin
                        state_d = StRead;
                    end else if (!cs_n_s && !wr_n_s && rd_n_s) begin
                        state_d = StWrite;
                    end
                end
                StRead: begin
                    if (collide) begin
                        state_d   = StError;
                        err_entry = 1'b1;
                    end else if (rd_n_s || cs_n_s) begin
                        state_d = StIdle;
                    end
                end
                StWrite: begin
                    if (collide) begin
                        state_d   = StError;
                        err_entry = 1'b1;
                    end else if (wr_n_s || cs_n_s) begin
                        // Both were low on entry, so high here means a rising edge
                        state_d = StIdle;
                        commit  = 1'b1;
                    end
                end
                StError: begin
                    if (rd_n_s && wr_n_s) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StReset;
                end
            endcase
        end
    end

    // Boot counter: cleared while in RESET, counts through BOOT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == StReset) begin
            cnt_q <= '0;
        end else if (state_q == StBoot && !boot_done) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign reg_we = commit && in_range && !is_idr;

    // Register file: reloaded in RESET, written on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_WORDS; i++) begin
                regs_q[i] <= (i == 0) ? MrReset : 16'h0000;
            end
        end else if (state_q == StReset) begin
            for (int unsigned i = 0; i < REG_WORDS; i++) begin
                regs_q[i] <= (i == 0) ? MrReset : 16'h0000;
            end
        end else if (reg_we) begin
            regs_q[reg_idx] <= wr_hold_q;
        end
    end

    // Read word latched on entry to READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_q <= '0;
        end else if (state_q != StRead && state_d == StRead) begin
            rd_word_q <= map_word;
        end
    end

    // Write data tracks the bus every WRITE cycle; commit uses the previous
    // cycle's copy, i.e. the last value seen with the strobe still low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_hold_q <= '0;
        end else if (state_q == StWrite) begin
            wr_hold_q <= data_s;
        end
    end

    // Commit event pulse and its address/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_evt_q      <= 1'b0;
            wr_evt_addr_q <= '0;
            wr_evt_data_q <= '0;
        end else begin
            wr_evt_q <= commit;
            if (commit) begin
                wr_evt_addr_q <= addr_s;
                wr_evt_data_q <= wr_hold_q;
            end
        end
    end

    assign wr_evt      = wr_evt_q;
    assign wr_evt_addr = wr_evt_addr_q;
    assign wr_evt_data = wr_evt_data_q;

    assign busy = (state_q == StReset) || (state_q == StBoot);

    // Enable from raw pins so the bus is released as soon as the host lets go
    assign rd_oe = !bus.cs_n && !bus.rd_n && !busy;
    assign data  = rd_oe ? rd_word_q : 16'hzzzz;

`ifdef W5300_RSP_ERR_CNT_EN
    logic       rd_n_p, wr_n_p;
    logic       rd_fall, wr_fall;
    logic [7:0] err_cnt_q;
    logic [8:0] err_sum;

    assign rd_fall = rd_n_p && !rd_n_s && cs_n_s;
    assign wr_fall = wr_n_p && !wr_n_s && cs_n_s;
    assign err_sum = {1'b0, err_cnt_q} + 9'(err_entry) + 9'(rd_fall) + 9'(wr_fall);

    // Saturating error counter; survives chip reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_n_p    <= 1'b1;
            wr_n_p    <= 1'b1;
            err_cnt_q <= '0;
        end else begin
            rd_n_p    <= rd_n_s;
            wr_n_p    <= wr_n_s;
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
